// File: rtl/pe_bus_arbiter_pkg.sv
// Shared definitions for the PE bus arbiter: FSM encoding and request-index decode.
package pe_bus_arbiter_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StArb  = 1'b1
  } arb_state_e;

  // A request index of zero means the PE has nothing to send this cycle.
  localparam int unsigned NoRequestIdx = 0;

endpackage

// File: rtl/pe_bus_arbiter_rr_priority_picker.sv
// Round-robin priority picker: first set request at or after ptr, wrapping, as a one-hot grant.
module pe_bus_arbiter_rr_priority_picker #(
  parameter int unsigned logNumPe = 3
) (
  input  logic [(1<<logNumPe)-1:0] req,
  input  logic [logNumPe-1:0]      ptr,
  output logic [(1<<logNumPe)-1:0] grant,
  output logic                     found,
  output logic [logNumPe-1:0]      win_id
);

  localparam int unsigned NumPe = 1 << logNumPe;

  logic [logNumPe-1:0] idx;

  // Adding the offset at pointer width wraps naturally because NumPe is a power of two.
  always_comb begin
    grant  = '0;
    found  = 1'b0;
    win_id = '0;
    idx    = '0;
    for (int unsigned off = 0; off < NumPe; off++) begin
      idx = ptr + logNumPe'(off);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
        win_id     = idx;
      end
    end
  end

endmodule

// File: rtl/pe_bus_arbiter.sv
// Shared PE bus arbiter: round-robin grant among PEs, one registered transfer per cycle.
module pe_bus_arbiter
  import pe_bus_arbiter_pkg::*;
#(
  parameter int unsigned logNumPe      = 3,
  parameter int unsigned dataLen       = 16,
  parameter int unsigned peBusIndexLen = logNumPe + 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic                                  stop,
  input  logic [(1<<logNumPe)*dataLen-1:0]       req_data,
  input  logic [(1<<logNumPe)*peBusIndexLen-1:0] req_index,
  output logic [(1<<logNumPe)-1:0]               contention,
  output logic [dataLen-1:0]                    bus_data_out,
  output logic [(1<<logNumPe)-1:0]               bus_data_out_v,
  output logic [15:0]                           grant_count,
  output logic                                  index_err
);

  localparam int unsigned NumPe = 1 << logNumPe;
  localparam logic [peBusIndexLen-1:0] MaxIdx  = peBusIndexLen'(NumPe);
  localparam logic [peBusIndexLen-1:0] NoReq   = peBusIndexLen'(NoRequestIdx);
  localparam logic [NumPe-1:0]         OneHot0 = NumPe'(1);

  arb_state_e state_q, state_d;
  logic       arb_en;

  logic [peBusIndexLen-1:0] idx [NumPe];
  logic [dataLen-1:0]       dat [NumPe];
  logic [NumPe-1:0]         valid, oor;

  logic [NumPe-1:0]    grant;
  logic                found, grant_en;
  logic [logNumPe-1:0] win_id, rr_ptr, dst;

  always_comb begin
    valid = '0;
    oor   = '0;
    for (int unsigned i = 0; i < NumPe; i++) begin
      idx[i]   = req_index[i*peBusIndexLen +: peBusIndexLen];
      dat[i]   = req_data[i*dataLen +: dataLen];
      valid[i] = (idx[i] != NoReq) && (idx[i] <= MaxIdx);
      oor[i]   = idx[i] > MaxIdx;
    end
  end

  pe_bus_arbiter_rr_priority_picker #(
    .logNumPe(logNumPe)
  ) u_rr_priority_picker (
    .req   (valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .found (found),
    .win_id(win_id)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start && !stop) state_d = StArb;
      StArb:   if (stop && !start) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    arb_en = (state_q == StArb);
  end

  assign grant_en   = arb_en && found;
  assign contention = valid & ~(grant & {NumPe{grant_en}});
  // Winner's index is known valid here, so index-1 fits the PE id width.
  assign dst        = logNumPe'(idx[win_id] - 1'b1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr         <= '0;
      bus_data_out   <= '0;
      bus_data_out_v <= '0;
      grant_count    <= '0;
      index_err      <= 1'b0;
    end else begin
      if (grant_en) begin
        rr_ptr         <= win_id + 1'b1;
        bus_data_out   <= dat[win_id];
        bus_data_out_v <= OneHot0 << dst;
        if (grant_count != 16'hFFFF) grant_count <= grant_count + 16'd1;
      end else begin
        bus_data_out_v <= '0;
      end
      if (|oor) index_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pe_bus_arbiter.sv
// Self-checking bench for pe_bus_arbiter: directed vector table, corner sequences, random vs model.
module tb_pe_bus_arbiter;

  localparam int NumPe   = 8;
  localparam int DataLen = 16;
  localparam int IdxLen  = 4;

  logic                      clk = 1'b0;
  logic                      reset, start, stop;
  logic [NumPe*DataLen-1:0]  req_data;
  logic [NumPe*IdxLen-1:0]   req_index;
  logic [NumPe-1:0]          contention, bus_data_out_v;
  logic [DataLen-1:0]        bus_data_out;
  logic [15:0]               grant_count;
  logic                      index_err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit         m_arb;
  int         m_ptr;
  logic [15:0] m_data;
  logic [7:0] m_v;
  int         m_cnt;
  bit         m_err;

  typedef struct {
    bit           start;
    bit           stop;
    logic [31:0]  idx;
    logic [127:0] data;
    logic [7:0]   cont;
    logic [7:0]   v;
    logic [15:0]  dout;
    logic [15:0]  cnt;
    bit           err;
  } vec_t;

  vec_t vecs [11];

  pe_bus_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .stop          (stop),
    .req_data      (req_data),
    .req_index     (req_index),
    .contention    (contention),
    .bus_data_out  (bus_data_out),
    .bus_data_out_v(bus_data_out_v),
    .grant_count   (grant_count),
    .index_err     (index_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_arb  = 1'b0;
    m_ptr  = 0;
    m_data = '0;
    m_v    = '0;
    m_cnt  = 0;
    m_err  = 1'b0;
  endtask

  // Called at a negedge: drive inputs, check contention, take the edge, check outputs.
  task automatic step(input bit st, input bit sp, input logic [31:0] iv, input logic [127:0] dv,
                      output logic [7:0] got_cont);
    int         ix [NumPe];
    logic [7:0] vld;
    logic [7:0] exp_cont;
    int         w;
    start     = st;
    stop      = sp;
    req_index = iv;
    req_data  = dv;
    #1;
    vld = '0;
    for (int i = 0; i < NumPe; i++) begin
      ix[i]  = int'(iv[i*IdxLen +: IdxLen]);
      vld[i] = (ix[i] >= 1) && (ix[i] <= NumPe);
    end
    w = -1;
    if (m_arb) begin
      for (int k = 0; k < NumPe; k++) begin
        if (w < 0 && vld[(m_ptr + k) % NumPe]) w = (m_ptr + k) % NumPe;
      end
    end
    exp_cont = vld;
    if (w >= 0) exp_cont[w] = 1'b0;
    got_cont = contention;
    check("contention", 32'(contention), 32'(exp_cont));
    @(posedge clk);
    #1;
    if (w >= 0) begin
      m_data = dv[w*DataLen +: DataLen];
      m_v    = 8'(1 << (ix[w] - 1));
      if (m_cnt < 16'hFFFF) m_cnt++;
      m_ptr  = (w + 1) % NumPe;
    end else begin
      m_v = '0;
    end
    for (int i = 0; i < NumPe; i++) if (ix[i] > NumPe) m_err = 1'b1;
    if (st && !sp) m_arb = 1'b1;
    else if (sp && !st) m_arb = 1'b0;
    check("bus_data_out", 32'(bus_data_out), 32'(m_data));
    check("bus_data_out_v", 32'(bus_data_out_v), 32'(m_v));
    check("grant_count", 32'(grant_count), 32'(m_cnt));
    check("index_err", 32'(index_err), 32'(m_err));
    check("onehot_v", 32'($countones(bus_data_out_v) <= 1), 32'd1);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    check("rst_data", 32'(bus_data_out), 32'd0);
    check("rst_v", 32'(bus_data_out_v), 32'd0);
    check("rst_cnt", 32'(grant_count), 32'd0);
    check("rst_err", 32'(index_err), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0]   c;
    logic [31:0]  iv;
    logic [127:0] dv;
    int           r;

    vecs[0]  = '{0, 0, 32'h0000_0100, 128'h0000_0000_0000_0000_0000_2222_0000_0000,
                 8'h04, 8'h00, 16'h0000, 16'd0, 0};
    vecs[1]  = vecs[0];
    vecs[2]  = '{1, 0, 32'h0, 128'h0, 8'h00, 8'h00, 16'h0000, 16'd0, 0};
    vecs[3]  = '{0, 0, 32'h0000_0003, 128'h0000_0000_0000_0000_0000_0000_0000_00A5,
                 8'h00, 8'h04, 16'h00A5, 16'd1, 0};
    vecs[4]  = '{0, 0, 32'h0805_0010, 128'h0000_6666_0000_4444_0000_0000_1111_0000,
                 8'h50, 8'h01, 16'h1111, 16'd2, 0};
    vecs[5]  = '{0, 0, 32'h0805_0010, 128'h0000_6666_0000_4444_0000_0000_1111_0000,
                 8'h42, 8'h10, 16'h4444, 16'd3, 0};
    vecs[6]  = '{0, 0, 32'h0805_0010, 128'h0000_6666_0000_4444_0000_0000_1111_0000,
                 8'h12, 8'h80, 16'h6666, 16'd4, 0};
    vecs[7]  = '{0, 0, 32'h0805_0010, 128'h0000_6666_0000_4444_0000_0000_1111_0000,
                 8'h50, 8'h01, 16'h1111, 16'd5, 0};
    vecs[8]  = '{0, 0, 32'h00C0_0000, 128'h0000_0000_5555_0000_0000_0000_0000_0000,
                 8'h00, 8'h00, 16'h1111, 16'd5, 1};
    vecs[9]  = '{0, 1, 32'h0000_2000, 128'h0000_0000_0000_0000_3333_0000_0000_0000,
                 8'h00, 8'h02, 16'h3333, 16'd6, 1};
    vecs[10] = '{0, 0, 32'h0000_2000, 128'h0000_0000_0000_0000_3333_0000_0000_0000,
                 8'h08, 8'h00, 16'h3333, 16'd6, 1};

    reset     = 1'b1;
    start     = 1'b0;
    stop      = 1'b0;
    req_index = '0;
    req_data  = '0;
    model_reset();
    @(negedge clk);
    apply_reset();

    for (int i = 0; i < 11; i++) begin
      step(vecs[i].start, vecs[i].stop, vecs[i].idx, vecs[i].data, c);
      check($sformatf("vec%0d_cont", i), 32'(c), 32'(vecs[i].cont));
      check($sformatf("vec%0d_v", i), 32'(bus_data_out_v), 32'(vecs[i].v));
      check($sformatf("vec%0d_dout", i), 32'(bus_data_out), 32'(vecs[i].dout));
      check($sformatf("vec%0d_cnt", i), 32'(grant_count), 32'(vecs[i].cnt));
      check($sformatf("vec%0d_err", i), 32'(index_err), 32'(vecs[i].err));
    end

    // Sticky error survives idle cycles, clears only on reset.
    step(0, 0, 32'h0, 128'h0, c);
    check("err_sticky", 32'(index_err), 32'd1);
    apply_reset();

    // Reset asserted between edges while a transfer is on the outputs.
    step(1, 0, 32'h0, 128'h0, c);
    step(0, 0, 32'h0000_0300, 128'h0000_0000_0000_0000_0000_BEEF_0000_0000, c);
    check("pre_rst_dout", 32'(bus_data_out), 32'h0000_BEEF);
    reset = 1'b1;
    #1;
    check("midrst_dout", 32'(bus_data_out), 32'd0);
    check("midrst_v", 32'(bus_data_out_v), 32'd0);
    check("midrst_cnt", 32'(grant_count), 32'd0);
    check("midrst_cont", 32'(contention), 32'h04);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    // No grant before start even with requests pending.
    step(0, 0, 32'h1000_0001, 128'hAAAA_0000_0000_0000_0000_0000_0000_5A5A, c);
    step(1, 0, 32'h1000_0001, 128'hAAAA_0000_0000_0000_0000_0000_0000_5A5A, c);
    // Pointer back at 0: PE0 wins over PE7.
    step(0, 0, 32'h1000_0001, 128'hAAAA_0000_0000_0000_0000_0000_0000_5A5A, c);
    check("ptr0_dout", 32'(bus_data_out), 32'h0000_5A5A);
    check("ptr0_cont", 32'(c), 32'h80);
    // start and stop together leave ARB unchanged.
    step(1, 1, 32'h1000_0001, 128'hAAAA_0000_0000_0000_0000_0000_0000_5A5A, c);
    check("both_dout", 32'(bus_data_out), 32'h0000_AAAA);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NumPe; i++) begin
        r = int'($urandom_range(0, 99));
        if (r < 40)      iv[i*IdxLen +: IdxLen] = 4'd0;
        else if (r < 98) iv[i*IdxLen +: IdxLen] = 4'($urandom_range(1, 8));
        else             iv[i*IdxLen +: IdxLen] = 4'($urandom_range(9, 15));
        dv[i*DataLen +: DataLen] = 16'($urandom);
      end
      step($urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, iv, dv, c);
      if (n == 1500) apply_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_bus_arbiter.md
PE_BUS_ARBITER -- requirements
Module: pe_bus_arbiter

Interface
REQ-001 Parameter logNumPe, default 3, log2 of PEs sharing the PE bus; numPe = 2^logNumPe.
REQ-002 Parameter dataLen, default 16, bus data width.
REQ-003 Parameter peBusIndexLen, default logNumPe+1, request index width.
REQ-004 Port clk  input  1  sole clock; all state rising-edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port start  input  1  one-cycle pulse; enables arbitration.
REQ-007 Port stop  input  1  one-cycle pulse; disables arbitration.
REQ-008 Port req_data  input  numPe*dataLen  per-PE bus data; PE i in slice [i*dataLen +: dataLen].
REQ-009 Port req_index  input  numPe*peBusIndexLen  per-PE destination index, same slicing; 0 = no request, k in 1..numPe = deliver to PE k-1.
REQ-010 Port contention  output  numPe  bit i high = PE i's request not taken this cycle; PE must hold it.
REQ-011 Port bus_data_out  output  dataLen  registered winning data.
REQ-012 Port bus_data_out_v  output  numPe  registered one-hot destination valid.
REQ-013 Port grant_count  output  16  saturating count of granted transfers.
REQ-014 Port index_err  output  1  sticky; set on any out-of-range index (> numPe).

Function
REQ-015 FSM states IDLE, ARB; IDLE after reset.
REQ-016 IDLE -> ARB on start; ARB -> IDLE on stop; start and stop together -> state unchanged.
REQ-017 Valid request from PE i: req_index in 1..numPe; index 0 and out-of-range are not requests.
REQ-018 Out-of-range index: request dropped, never contended, index_err set next edge, held until reset.
REQ-019 In IDLE: no grant; contention = valid-request vector; outputs invalid next cycle.
REQ-020 In ARB: round-robin; winner = first valid requester at/after rr_ptr, wrapping numPe-1 -> 0.
REQ-021 After a grant to PE w, rr_ptr <= (w+1) mod numPe; no grant leaves rr_ptr unchanged.
REQ-022 contention combinational, same cycle: high for every valid requester except the winner.
REQ-023 Latency 1: edge after grant, bus_data_out <= winner data, bus_data_out_v <= one-hot(index-1).
REQ-024 Cycle without grant: bus_data_out_v <= 0; bus_data_out holds last value.
REQ-025 Self-addressed request (index-1 == own id) is legal and delivered normally.
REQ-026 grant_count increments per grant, saturates at 16'hFFFF.
REQ-027 stop same cycle as a grant: that grant completes; no grant from the next cycle.
REQ-028 At most one bus_data_out_v bit high in any cycle.

Reset
REQ-029 Reset asserted: state=IDLE, rr_ptr=0, bus_data_out=0, bus_data_out_v=0, grant_count=0, index_err=0, immediately, regardless of clk.
REQ-030 Reset mid-transfer: in-flight output discarded; contention combinationally reflects IDLE.
REQ-031 First grant only after reset deasserted and start pulsed.

Structure
REQ-032 FSM state encoding and the index-decode constant (0 = no request) in the shared package.
REQ-033 One sub-module natural: rr_priority_picker (request vector + pointer -> one-hot winner); rest inline.

Verification
REQ-034 Reset, no start, PE2 index=1 -> contention[2]=1, bus_data_out_v=0 indefinitely.
REQ-035 start; PE0 index=3 data=16'h00A5 -> next cycle bus_data_out=16'h00A5, bus_data_out_v=8'b0000_0100, grant_count=1.
REQ-036 ARB, PEs 1,4,6 requesting continuously, rr_ptr=0 -> grants 1,4,6,1; contention exactly the non-winners each cycle.
REQ-037 PE5 index=4'd12 -> no grant, no contention on bit 5, index_err=1 from next cycle until reset.
REQ-038 stop with PE3 granted same cycle -> PE3 data delivered next cycle; later requests contended, no output.
REQ-039 Reset asserted between edges during a grant -> outputs zero immediately; grant_count=0; rr_ptr=0 after release.
